spike_addr_tx: RTL and testbench
================================

// Module: spike_addr_tx
// PURPOSE
// - Transmit end of the spike-address interface consumed by the per-neuron MAC units.
// - Captures one timestep's fired-neuron vector from a neuron cluster at the timestep boundary.
// - Serialises every set bit into a 12-bit source address, one per accepted cycle, under valid/ready.
// - Reports completion so the timestep controller can raise the MAC clear.
// PARAMETERS
// - NUM_NEURONS  20    neurons in the local cluster (1..64)
// - ADDR_BITS    12    source address width; matches the MAC source_address input
// - BASE_ADDR    0     global address of local neuron 0; neuron i -> BASE_ADDR+i
// - IDLE_ADDR    12'hFFF  address driven while not valid; never a configured source address
// PORTS
// - CLK            in   1            single clock, all logic on posedge
// - RESET_N        in   1            synchronous, active-low reset
// - spikes_in      in   NUM_NEURONS  fired flags from the neuron cluster, bit i = neuron i
// - timestep_end   in   1            1-cycle pulse: sample spikes_in this cycle
// - addr_out       out  ADDR_BITS    source address; IDLE_ADDR when addr_valid=0
// - addr_valid     out  1            addr_out holds a spike address
// - addr_ready     in   1            downstream accepts addr_out this cycle
// - tx_done        out  1            1-cycle pulse: last pending address accepted
// - busy           out  1            pending vector non-zero
// - overrun        out  1            sticky: timestep_end arrived while busy
// BEHAVIOUR
// - Reset (RESET_N=0 at posedge): pending=0, state=IDLE, addr_out=IDLE_ADDR, addr_valid=0,
//   tx_done=0, busy=0, overrun=0. Reset mid-transfer discards all pending spikes.
// - FSM: IDLE -> SEND when timestep_end && |spikes_in. IDLE stays when spikes_in==0;
//   tx_done still pulses one cycle after that timestep_end (empty timestep completes).
// - SEND: addr_out = BASE_ADDR + index of lowest set pending bit; addr_valid=1; registered outputs.
// - Transfer = addr_valid && addr_ready at posedge: clear that bit; next lowest bit presented next cycle
//   (1 address per cycle at full throughput). addr_out/addr_valid held stable while addr_ready=0.
// - Last bit accepted -> IDLE, addr_valid=0, tx_done=1 next cycle, addr_out=IDLE_ADDR.
// - Latency: timestep_end at cycle n -> first addr_valid at n+1; K spikes with ready=1 -> tx_done at n+K+1.
// - timestep_end while busy: new spikes_in OR'd into pending (already-sent bits may re-send),
//   overrun set until reset. Simultaneous transfer+capture: clear the sent bit first, then OR.
// - Address arithmetic modulo 2^ADDR_BITS; BASE_ADDR+NUM_NEURONS-1 must not equal IDLE_ADDR (elab error).
// CONFIGURATION
// - SPIKE_TX_COUNT_EN defined: extra output spike_count [ADDR_BITS-1:0] = addresses accepted in the
//   last completed timestep, updated with tx_done, reset 0, saturating at all-ones.
// - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
// - Package spike_noc_pkg: ADDR_BITS, IDLE_ADDR, tx state enum {IDLE,SEND}, addr_t typedef;
//   shared with MAC and router blocks.
// - Sub-module spike_prio_enc: combinational lowest-set-bit encoder, NUM_NEURONS in ->
//   index + any_set out. Top holds pending register, FSM, output registers, counter.
// TESTING
// - Reset: RESET_N=0 two cycles mid-SEND -> addr_valid=0, addr_out=12'hFFF, busy=0, overrun=0.
// - spikes_in=20'h00081, ready=1, pulse -> addr 0 then 7 on consecutive cycles, tx_done at n+3.
// - Backpressure: spikes_in=bit3, ready=0 for 5 cycles -> addr_out=3 held valid; accepted when ready=1.
// - Empty timestep: spikes_in=0 pulse -> no addr_valid, tx_done one cycle later.
// - Overrun: bits {1,2}, ready=0, second pulse with bit 9 -> overrun=1, sends 1,2,9 in order.
// - SPIKE_TX_COUNT_EN: all 20 bits, ready=1 -> addresses 0..19, spike_count=20 with tx_done.

Source files
------------

// File: rtl/spike_noc_pkg.sv
// Shared spike-NoC definitions: address width, idle address, transmit FSM states.
// Used by the spike transmitter, MAC units and router blocks.
package spike_noc_pkg;

    localparam int ADDR_BITS = 12;

    typedef logic [ADDR_BITS-1:0] addr_t;

    // Reserved value on the address bus whenever no spike is being presented.
    localparam addr_t IDLE_ADDR = 12'hFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    function automatic addr_t sat_inc(input addr_t value);
        return (value == '1) ? value : value + addr_t'(1);
    endfunction

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest 1 in vec, plus any_set.
module spike_prio_enc #(
    parameter int WIDTH = 20,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any_set
);

    // Scanning downwards lets the lowest set bit be the last assignment to win.
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign any_set = |vec;

endmodule

// File: rtl/spike_addr_tx.sv
// Spike-address transmitter: captures the fired-neuron vector at timestep_end and
// serialises it lowest-first as source addresses under valid/ready.
// Optional macro SPIKE_TX_COUNT_EN adds the spike_count output.
module spike_addr_tx
    import spike_noc_pkg::*;
#(
    parameter int    NUM_NEURONS = 20,
    parameter addr_t BASE_ADDR   = '0
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    input  logic                   timestep_end,
    output addr_t                  addr_out,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic                   tx_done,
    output logic                   busy,
    output logic                   overrun
`ifdef SPIKE_TX_COUNT_EN
    ,
    output addr_t                  spike_count
`endif
);

    localparam int    IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam addr_t IDLE_OFFSET = IDLE_ADDR - BASE_ADDR;

    // The configured window BASE_ADDR..BASE_ADDR+NUM_NEURONS-1 (modulo) must not hit IDLE_ADDR.
    generate
        if (NUM_NEURONS < 1 || NUM_NEURONS > 64) begin : g_bad_size
            $error("spike_addr_tx: NUM_NEURONS must be in 1..64");
        end
        if (int'(IDLE_OFFSET) < NUM_NEURONS) begin : g_bad_base
            $error("spike_addr_tx: a neuron address collides with IDLE_ADDR");
        end
    endgenerate

    tx_state_t              state, state_next;
    logic [NUM_NEURONS-1:0] pending, pending_next;
    logic [IDX_W-1:0]       next_idx;
    logic                   next_any;
    logic                   xfer;
    logic                   done_next;

    assign xfer = addr_valid && addr_ready;
    assign busy = (state == SEND);

    // Encoding the next pending vector lets the address outputs be registered
    // while still appearing the cycle after capture.
    spike_prio_enc #(
        .WIDTH (NUM_NEURONS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .vec     (pending_next),
        .idx     (next_idx),
        .any_set (next_any)
    );

    always_comb begin
        // NOTE: every signal driven here is given a default first, so no path can infer a latch.
        pending_next = pending;
        if (xfer) pending_next = pending & (pending - NUM_NEURONS'(1));
        if (timestep_end) pending_next = pending_next | spikes_in;
        state_next = next_any ? SEND : IDLE;
        done_next  = (busy || timestep_end) && !next_any;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!RESET_N) begin
            state      <= IDLE;
            pending    <= '0;
            addr_out   <= IDLE_ADDR;
            addr_valid <= 1'b0;
            tx_done    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            pending    <= pending_next;
            addr_valid <= next_any;
            addr_out   <= next_any ? BASE_ADDR + addr_t'(next_idx) : IDLE_ADDR;
            tx_done    <= done_next;
            if (timestep_end && busy) overrun <= 1'b1;
        end
    end

`ifdef SPIKE_TX_COUNT_EN
    addr_t accepted, accepted_next;

    assign accepted_next = xfer ? sat_inc(accepted) : accepted;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            accepted    <= '0;
            spike_count <= '0;
        end else if (done_next) begin
            accepted    <= '0;
            spike_count <= accepted_next;
        end else begin
            accepted    <= accepted_next;
        end
    end
`endif

endmodule

// File: tb/tb_spike_addr_tx.sv
// Directed bench for spike_addr_tx: table-driven vectors plus hand-written
// overrun, full-vector and mid-transfer reset sequences.
module tb_spike_addr_tx;
    import spike_noc_pkg::*;

    localparam int N = 20;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [N-1:0] spikes_in;
    logic         timestep_end;
    logic         addr_ready;
    addr_t        addr_out;
    logic         addr_valid;
    logic         tx_done;
    logic         busy;
    logic         overrun;
`ifdef SPIKE_TX_COUNT_EN
    addr_t        spike_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    spike_addr_tx #(
        .NUM_NEURONS (N),
        .BASE_ADDR   (12'h000)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .spikes_in    (spikes_in),
        .timestep_end (timestep_end),
        .addr_out     (addr_out),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .tx_done      (tx_done),
        .busy         (busy),
        .overrun      (overrun)
`ifdef SPIKE_TX_COUNT_EN
        ,
        .spike_count  (spike_count)
`endif
    );

    typedef struct {
        logic [N-1:0] spikes;
        logic         tse;
        logic         ready;
        addr_t        addr;
        logic         valid;
        logic         done;
        logic         bsy;
        logic         ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [N-1:0] s, input logic t, input logic r,
                                input addr_t a, input logic v, input logic d,
                                input logic b, input logic o);
        vec_t x;
        x.spikes = s; x.tse = t; x.ready = r; x.addr = a;
        x.valid = v; x.done = d; x.bsy = b; x.ovr = o;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input addr_t a, input logic v,
                              input logic d, input logic b, input logic o);
        check({tag, ".addr_out"},   32'(addr_out),   32'(a));
        check({tag, ".addr_valid"}, 32'(addr_valid), 32'(v));
        check({tag, ".tx_done"},    32'(tx_done),    32'(d));
        check({tag, ".busy"},       32'(busy),       32'(b));
        check({tag, ".overrun"},    32'(overrun),    32'(o));
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N      = 1'b0;
        spikes_in    = '0;
        timestep_end = 1'b0;
        addr_ready   = 1'b0;
        step();
        step();
        check_outs("reset", IDLE_ADDR, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SPIKE_TX_COUNT_EN
        check("reset.spike_count", 32'(spike_count), 32'd0);
`endif
        RESET_N = 1'b1;

        // Two spikes (neurons 0 and 7), full throughput: 0, 7, then tx_done.
        vecs.push_back(mk(20'h00081, 1, 1, 12'h000, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 1, 12'h007, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 0, 0, 0));
        // Empty timestep still completes one cycle later.
        vecs.push_back(mk(20'h00000, 1, 1, IDLE_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 0, 0, 0));
        // Backpressure: neuron 3 held for five cycles of ready=0.
        vecs.push_back(mk(20'h00008, 1, 0, 12'h003, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 0, 12'h003, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 0, 12'h003, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 0, 12'h003, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 0, 12'h003, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 0, 0, 0));
        // Edge neurons 0 and 19.
        vecs.push_back(mk(20'h80001, 1, 1, 12'h000, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 1, 12'h013, 1, 0, 1, 0));
        vecs.push_back(mk(20'h00000, 0, 1, IDLE_ADDR, 0, 1, 0, 0));

        foreach (vecs[i]) begin
            spikes_in    = vecs[i].spikes;
            timestep_end = vecs[i].tse;
            addr_ready   = vecs[i].ready;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid,
                       vecs[i].done, vecs[i].bsy, vecs[i].ovr);
        end

        // Overrun: {1,2} pending under backpressure, then a second capture adds 9.
        spikes_in = 20'h00006; timestep_end = 1'b1; addr_ready = 1'b0;
        step();
        check_outs("ovr0", 12'h001, 1, 0, 1, 0);
        spikes_in = 20'h00200;
        step();
        check_outs("ovr1", 12'h001, 1, 0, 1, 1);
        spikes_in = '0; timestep_end = 1'b0; addr_ready = 1'b1;
        step();
        check_outs("ovr2", 12'h002, 1, 0, 1, 1);
        step();
        check_outs("ovr3", 12'h009, 1, 0, 1, 1);
        step();
        check_outs("ovr4", IDLE_ADDR, 0, 1, 0, 1);

        // All neurons fire: addresses 0..19 back to back.
        spikes_in = '1; timestep_end = 1'b1; addr_ready = 1'b1;
        step();
        spikes_in = '0; timestep_end = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("all.addr%0d", i), 32'(addr_out), 32'(i));
            check($sformatf("all.valid%0d", i), 32'(addr_valid), 32'd1);
            step();
        end
        check("all.tx_done", 32'(tx_done), 32'd1);
        check("all.addr_valid_end", 32'(addr_valid), 32'd0);
`ifdef SPIKE_TX_COUNT_EN
        check("all.spike_count", 32'(spike_count), 32'd20);
`endif

        // Reset held two cycles in the middle of a transfer discards pending spikes.
        spikes_in = 20'h000F0; timestep_end = 1'b1; addr_ready = 1'b0;
        step();
        check("rst_mid.addr_out", 32'(addr_out), 32'h004);
        spikes_in = '0; timestep_end = 1'b0;
        RESET_N = 1'b0;
        step();
        step();
        check_outs("rst_mid", IDLE_ADDR, 0, 0, 0, 0);
`ifdef SPIKE_TX_COUNT_EN
        check("rst_mid.spike_count", 32'(spike_count), 32'd0);
`endif
        RESET_N = 1'b1; addr_ready = 1'b1;
        step();
        check_outs("post_rst", IDLE_ADDR, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
